// File: rtl/cond_operand_sequencer.sv
// Operand sequencer for the conditional-select mux: captures an (a, b) pair,
// then holds sel low for HOLD cycles and high for HOLD cycles before reporting done.
module cond_operand_sequencer #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             run,
  input  logic             flush,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             sel,
  output logic             busy,
  output logic             pair_done,
  output logic [7:0]       pair_count
);

  typedef enum logic [1:0] {IDLE, PHASE0, PHASE1} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] a_n, b_n;
  logic             sel_n, busy_n, done_n;
  logic [7:0]       count_n;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      a          <= '0;
      b          <= '0;
      sel        <= 1'b0;
      busy       <= 1'b0;
      pair_done  <= 1'b0;
      pair_count <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      a          <= a_n;
      b          <= b_n;
      sel        <= sel_n;
      busy       <= busy_n;
      pair_done  <= done_n;
      pair_count <= count_n;
    end
  end

  // flush overrides everything, including a handshake offered on the same edge
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = a;
    b_n     = b;
    sel_n   = sel;
    busy_n  = busy;
    done_n  = 1'b0;
    count_n = pair_count;
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
      sel_n   = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_n     = in_a;
            b_n     = in_b;
            cnt_n   = '0;
            sel_n   = 1'b0;
            busy_n  = 1'b1;
            state_n = PHASE0;
          end
        end
        PHASE0: begin
          if (run) begin
            if (cnt == LAST) begin
              cnt_n   = '0;
              sel_n   = 1'b1;
              state_n = PHASE1;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
        PHASE1: begin
          if (run) begin
            if (cnt == LAST) begin
              cnt_n   = '0;
              sel_n   = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              count_n = pair_count + 8'd1;
              state_n = IDLE;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state_n = IDLE;
          sel_n   = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

endmodule
